// File: rtl/seven_segment_scan_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions,
// the hex glyph table (active-high, {a,b,c,d,e,f,g}) and a width helper.
package seven_segment_scan_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  // Ceiling log2, never less than 1 so counters always get a real bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_scan_hex_to_seg.sv
// Combinational nibble-to-glyph decoder, active-high segments {a..g}.
module seven_segment_scan_hex_to_seg
  import seven_segment_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH[nibble];

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous
// value commit, per-digit dp/blanking and leading-zero suppression.
module seven_segment_scan
  import seven_segment_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CNT_W = clog2_min1(CLK_DIV);
  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] digit_nz;
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic                  upper_nz;
  logic [3:0]            sel_nibble;
  logic                  sel_dp, sel_blank, sel_suppress;
  logic [6:0]            glyph;

  // Holding rst keeps tick low so frame_done cannot pulse during reset.
  assign tick       = (cnt_q == CNT_LAST) && !rst;
  assign boundary   = tick && (idx_q == IDX_LAST);
  assign frame_done = boundary;
  assign pending    = pending_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

  // A blanked digit never holds off suppression of the digits below it.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_nz[gi]  = (act_data_q[4*gi +: 4] != 4'h0) && !act_blank_q[gi];
      assign an_onehot[gi] = (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    upper_nz = 1'b0;
    suppress = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_nz    = upper_nz | digit_nz[k];
      suppress[k] = (k != 0) && lz_en && !upper_nz;
    end
  end

  always_comb begin
    sel_nibble   = 4'h0;
    sel_dp       = 1'b0;
    sel_blank    = 1'b0;
    sel_suppress = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_nibble   = act_data_q[4*k +: 4];
        sel_dp       = act_dp_q[k];
        sel_blank    = act_blank_q[k];
        sel_suppress = suppress[k];
      end
    end
  end

  seven_segment_scan_hex_to_seg u_hex_to_seg (
    .nibble (sel_nibble),
    .seg    (glyph)
  );

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q;

    if (load) begin
      pend_data_d  = data_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pending_d    = 1'b1;
    end
    // A load landing on the boundary bypasses the pending stage.
    if (boundary && (pending_q || load)) begin
      act_data_d  = load ? data_in  : pend_data_q;
      act_dp_d    = load ? dp_in    : pend_dp_q;
      act_blank_d = load ? blank_in : pend_blank_q;
      pending_d   = 1'b0;
    end

    seg_d = ((sel_blank || sel_suppress) ? 7'h00 : glyph) ^ SEG_OFF;
    dp_d  = (sel_dp && !sel_blank) ^ DP_OFF;
    an_d  = (sel_blank ? '0 : an_onehot) ^ AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Cycle-level scoreboard bench for seven_segment_scan (4 digits, 4 clocks per digit).
module tb_seven_segment_scan;

  localparam int ND    = 4;
  localparam int CD    = 4;
  localparam int FRAME = ND * CD;

  localparam logic [6:0] GL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       pending;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in, blank_in;
  logic        load, lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done, pending;

  always #5 clk = ~clk;

  seven_segment_scan #(
    .NUM_DIGITS     (ND),
    .CLK_DIV        (CD),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .lz_en      (lz_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done),
    .pending    (pending)
  );

  int total = 0;
  int bad   = 0;
  out_t exp_q[$];

  // Reference state: what the display should hold, tracked by edge count.
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_act_bl, m_pend_dp, m_pend_bl;
  logic        m_pending;
  int          m_edges;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_clear();
    m_act = '0; m_pend = '0; m_act_dp = '0; m_act_bl = '0;
    m_pend_dp = '0; m_pend_bl = '0; m_pending = 1'b0; m_edges = 0;
  endtask

  // One clock: check frame_done, predict the post-edge outputs, then compare.
  task automatic step();
    out_t e, got;
    int   ed, d;
    logic up, sup;
    ed = m_edges + 1;
    check("frame_done", 32'(frame_done), 32'(!rst && (ed % FRAME == 0)));
    e = '0;
    if (rst) begin
      e.an = 4'hF;
      model_clear();
    end else begin
      d = ((ed - 1) / CD) % ND;
      if (m_act_bl[d]) begin
        e.an = 4'hF;
      end else begin
        up = 1'b0;
        for (int j = d; j < ND; j++)
          if (m_act[4*j +: 4] != 4'h0 && !m_act_bl[j]) up = 1'b1;
        sup   = lz_en && (d > 0) && !up;
        e.seg = sup ? 7'h00 : GL[m_act[4*d +: 4]];
        e.dp  = m_act_dp[d];
        e.an  = ~(4'b0001 << d);
      end
      if ((ed % FRAME == 0) && (m_pending || load)) begin
        m_act     = load ? data_in  : m_pend;
        m_act_dp  = load ? dp_in    : m_pend_dp;
        m_act_bl  = load ? blank_in : m_pend_bl;
        m_pending = 1'b0;
      end else if (load) begin
        m_pend    = data_in;
        m_pend_dp = dp_in;
        m_pend_bl = blank_in;
        m_pending = 1'b1;
      end
      e.pending = m_pending;
      m_edges   = ed;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = {seg, dp, an, pending};
    e   = exp_q.pop_front();
    check("outputs", 32'(got), 32'(e));
  endtask

  // Idle cycles with scrambled inputs that must be ignored without load.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = 4'($urandom);
      step();
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] blv);
    $display("load data=%h dp=%b blank=%b lz_en=%0d edge=%0d", v, dpv, blv, lz_en, m_edges + 1);
    data_in  = v;
    dp_in    = dpv;
    blank_in = blv;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic run_to_boundary();
    for (int i = 0; i < FRAME && ((m_edges + 1) % FRAME != 0); i++) run(1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lz_en = 1'b0;
    data_in = '0; dp_in = '0; blank_in = '0;
    model_clear();
    // load while in reset must be dropped
    step();
    load = 1'b1; data_in = 16'h7777;
    step();
    load = 1'b0;
    step();
    rst = 1'b0;
    run(36);

    run(5);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    run(2);
    do_load(16'h12AF, 4'b0000, 4'b0000);
    run(40);

    run_to_boundary();
    lz_en = 1'b1;
    do_load(16'h0008, 4'b0000, 4'b0000);
    run(36);

    run(3);
    do_load(16'h0000, 4'b0100, 4'b0000);
    run(40);

    lz_en = 1'b0;
    do_load(16'h9999, 4'b0000, 4'b1000);
    run(40);

    lz_en = 1'b1;
    do_load(16'h3050, 4'b0000, 4'b1000);
    run(36);

    lz_en = 1'b0;
    run_to_boundary();
    run(6);
    do_load(16'h5555, 4'b1111, 4'b0000);
    run(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display.
- Holds a multi-digit hex value, scans one digit per refresh slot, and decodes each nibble to segments.
- Per-digit decimal point, per-digit blanking and leading-zero suppression are supported.
- New values commit only at frame boundaries, so the display never shows a half-updated value. Sits between the user datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=1).
- CLK_DIV, 100000, clock cycles each digit stays lit (>=1); CLK_DIV=1 advances every cycle.
- SEG_ACTIVE_LOW, 0, 1 = segment/dp outputs asserted low.
- AN_ACTIVE_LOW, 1, 1 = digit-enable outputs asserted low.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- data_in  input  4*NUM_DIGITS  hex nibbles; nibble k = data_in[4k+3:4k], digit 0 least significant
- dp_in  input  NUM_DIGITS  decimal point request per digit
- blank_in  input  NUM_DIGITS  1 = digit fully dark (anode off)
- load  input  1  capture data_in/dp_in/blank_in into the pending register
- lz_en  input  1  leading-zero suppression enable (sampled live)
- seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0]
- dp  output  1  decimal point segment
- an  output  NUM_DIGITS  digit enables, one-hot when active
- frame_done  output  1  one-cycle pulse at end of each full scan
- pending  output  1  loaded value waiting for frame boundary

Behaviour:
- Reset (rst=1 at a clk edge):
  - Prescaler, digit index, active and pending registers all 0; pending=0; frame_done=0.
  - seg, dp and an at inactive levels. load is ignored while rst=1.
  - Reset mid-scan or with pending set discards everything and restarts at digit 0.
- Prescaler:
  - Counts 0..CLK_DIV-1. tick=1 when count==CLK_DIV-1; count then wraps to 0.
  - Width is clog2(CLK_DIV), minimum 1.
- Digit index:
  - Advances on tick, 0..NUM_DIGITS-1, then wraps to 0.
  - frame_done=1 for exactly the cycle tick occurs with index==NUM_DIGITS-1.
- Load/commit:
  - load=1 writes the pending registers and sets pending=1.
  - At frame boundary (the frame_done cycle), if pending=1 or load=1: active <= (load ? inputs : pending regs), and pending clears.
  - Load coincident with a boundary commits the new inputs directly.
  - Repeated loads within a frame: the last one wins.
  - The display changes only from digit 0 of the next frame.
- Output pipeline:
  - seg/dp/an are registered from the current index: one cycle latency after an index change.
  - First cycle after reset release: outputs still inactive. Second cycle: digit 0 of active (0 -> segments abcdef, anode 0 on).
- Decode (active-high before polarity):
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg.
- Blanking:
  - blank_in (active copy) set: anode, segments and dp all inactive for that slot. Scan timing is unchanged.
- Leading-zero suppression:
  - With lz_en=1, digit k>0 has segments off when nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
  - Anode stays on so dp still shows. A blanked digit does not count as nonzero.
- Polarity: SEG_ACTIVE_LOW inverts seg and dp; AN_ACTIVE_LOW inverts an. Inversion is applied at the output register only.
- NUM_DIGITS=1: index is constant 0 and frame_done pulses on every tick.

Decomposition:
- Shared include seven_seg_defs.vh:
  - segment-bit index constants SEG_A..SEG_G (6..0);
  - the 16-entry glyph constants;
  - clog2 helper function.
- Sub-module hex_to_seg: combinational 4-bit nibble -> 7-bit active-high segments. Instantiated once, after the digit mux.
- Prescaler, index, commit logic and output registers stay in the top module.

Test Plan:
- Reset with NUM_DIGITS=4, CLK_DIV=4, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0 -> an=4'b1111, seg=0 during reset; 2 cycles after release an=4'b1110, seg=7'b1111110; an steps 1101/1011/0111 every 4 cycles; frame_done pulses every 16 cycles.
- load data_in=16'h12AF mid-frame -> pending=1; display unchanged until the next frame_done; then digit0 seg=1000111 (F), digit1 1110111 (A), digit2 1101101 (2), digit3 0110000 (1); pending=0.
- load asserted exactly on the frame_done cycle with 16'h0008 -> committed that cycle; next frame digit0 shows 1111111; with lz_en=1, digits 1-3 have seg=0 but anodes still cycle.
- lz_en=1, value 16'h0000, dp_in=4'b0100 -> digit0 shows 0; digit2 seg=0, dp=1; digits 1 and 3 fully off segments.
- blank_in=4'b1000, value 16'h9999 -> digit3 anode never asserts; other digits show 1111011; the frame period stays 16 cycles.
- rst pulsed mid-frame with pending=1 -> pending=0, index restarts at 0, the display shows 0 in digit0, and the pending value is never shown.
